// File: rtl/adder_result_accumulator.sv
// Sums N_SAMPLES {cout,sum} adder results into an ACC_W-bit total with a sticky overflow flag.
// Latency: acc_valid rises one cycle after the final accepted sample. Backpressure: in_ready is low outside ACCUM, and the total is held until out_ready.
module adder_result_accumulator #(
    parameter int IN_W      = 4,
    parameter int ACC_W     = 8,
    parameter int N_SAMPLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  sum,
    input  logic             cout,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] sample_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last;
    logic [ACC_W:0]   acc_sum;

    // Accept is qualified by state, not by in_ready, so no input feeds in_ready.
    assign accept  = in_valid && (state == ACCUM);
    assign last    = (sample_cnt == CNT_W'(N_SAMPLES - 1));
    assign acc_sum = {1'b0, acc_out} + {{(ACC_W-IN_W){1'b0}}, cout, sum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)          state_nxt = ACCUM;
            ACCUM:   if (accept && last) state_nxt = HOLD;
            HOLD:    if (out_ready)      state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        acc_valid = 1'b0;
        case (state)
            ACCUM:   in_ready  = 1'b1;
            HOLD:    acc_valid = 1'b1;
            default: ;
        endcase
    end

    // The previous total stays visible in IDLE until the next start clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_out    <= '0;
            overflow   <= 1'b0;
            sample_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            acc_out    <= '0;
            overflow   <= 1'b0;
            sample_cnt <= '0;
        end else if (accept) begin
            acc_out    <= acc_sum[ACC_W-1:0];
            overflow   <= overflow | acc_sum[ACC_W];
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Randomized and directed bench for adder_result_accumulator; default instance plus a nine-sample instance for wrap-around.
module tb_adder_result_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, in_valid = 1'b0, cout = 1'b0, out_ready = 1'b0;
    logic [3:0] sum = '0;
    logic       in_ready, acc_valid, overflow;
    logic [7:0] acc_out;
    logic [2:0] sample_cnt;

    logic       start9 = 1'b0, in_valid9 = 1'b0, cout9 = 1'b0, out_ready9 = 1'b0;
    logic [3:0] sum9 = '0;
    logic       in_ready9, acc_valid9, overflow9;
    logic [7:0] acc_out9;
    logic [3:0] sample_cnt9;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder_result_accumulator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .cout(cout), .acc_out(acc_out), .acc_valid(acc_valid),
        .out_ready(out_ready), .overflow(overflow), .sample_cnt(sample_cnt)
    );

    adder_result_accumulator #(.IN_W(4), .ACC_W(8), .N_SAMPLES(9), .CNT_W(4)) dut9 (
        .clk(clk), .rst_n(rst_n), .start(start9), .in_valid(in_valid9), .in_ready(in_ready9),
        .sum(sum9), .cout(cout9), .acc_out(acc_out9), .acc_valid(acc_valid9),
        .out_ready(out_ready9), .overflow(overflow9), .sample_cnt(sample_cnt9)
    );

    // Adder result for operands a, b and carry-in c.
    function automatic logic [4:0] add4(input int a, input int b, input int c);
        return 5'(a + b + c);
    endfunction

    task automatic drive(input int a, input int b, input int c);
        {cout, sum} = add4(a, b, c);
    endtask

    task automatic drive9(input int a, input int b, input int c);
        {cout9, sum9} = add4(a, b, c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 0; in_valid = 0; out_ready = 0;
        start9 = 0; in_valid9 = 0; out_ready9 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pulses start in IDLE; returns at the negedge after the run has begun.
    task automatic begin_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({in_ready, acc_valid, overflow, acc_out, sample_cnt} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b ovf=%b acc=%0d cnt=%0d required all 0",
                     in_ready, acc_valid, overflow, acc_out, sample_cnt);
        end
        n_checks++;
        if ({in_ready9, acc_valid9, overflow9, acc_out9, sample_cnt9} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_state9: got rdy=%b vld=%b ovf=%b acc=%0d cnt=%0d required all 0",
                     in_ready9, acc_valid9, overflow9, acc_out9, sample_cnt9);
        end
    endtask

    task automatic test_basic();
        int ops[4][3] = '{'{3, 2, 1}, '{1, 0, 0}, '{12, 1, 0}, '{5, 7, 1}};
        int total = 0;
        @(negedge clk);
        begin_run();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (in_ready !== 1'b1 || acc_valid !== 1'b0 || acc_out !== 8'(total) || sample_cnt !== 3'(i)) begin
                n_fail++;
                $display("FAIL basic_step%0d: got rdy=%b vld=%b acc=%0d cnt=%0d required rdy=1 vld=0 acc=%0d cnt=%0d",
                         i, in_ready, acc_valid, acc_out, sample_cnt, total, i);
            end
            in_valid = 1'b1;
            drive(ops[i][0], ops[i][1], ops[i][2]);
            total += ops[i][0] + ops[i][1] + ops[i][2];
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (acc_valid !== 1'b1 || acc_out !== 8'h21 || overflow !== 1'b0 || sample_cnt !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_total: got vld=%b acc=%0d ovf=%b cnt=%0d rdy=%b required vld=1 acc=33 ovf=0 cnt=4 rdy=0",
                     acc_valid, acc_out, overflow, sample_cnt, in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (acc_valid !== 1'b0 || acc_out !== 8'h21 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_release: got vld=%b acc=%0d rdy=%b required vld=0 acc=33 rdy=0",
                     acc_valid, acc_out, in_ready);
        end
    endtask

    task automatic test_overflow();
        int total = 0;
        start9 = 1'b1;
        @(negedge clk);
        start9 = 1'b0;
        in_valid9 = 1'b1;
        drive9(15, 15, 1);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            total += 31;
            n_checks++;
            if (acc_out9 !== 8'(total % 256) || overflow9 !== (total >= 256) || sample_cnt9 !== 4'(i + 1)) begin
                n_fail++;
                $display("FAIL overflow_step%0d: got acc=%0d ovf=%b cnt=%0d required acc=%0d ovf=%0d cnt=%0d",
                         i, acc_out9, overflow9, sample_cnt9, total % 256, total >= 256, i + 1);
            end
        end
        in_valid9 = 1'b0;
        n_checks++;
        if (acc_valid9 !== 1'b1 || acc_out9 !== 8'h17 || overflow9 !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_final: got vld=%b acc=%0d ovf=%b required vld=1 acc=23 ovf=1",
                     acc_valid9, acc_out9, overflow9);
        end
        out_ready9 = 1'b1;
        @(negedge clk);
        out_ready9 = 1'b0;
        start9 = 1'b1;
        @(negedge clk);
        start9 = 1'b0;
        n_checks++;
        if (overflow9 !== 1'b0 || acc_out9 !== 8'd0 || in_ready9 !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_restart: got ovf=%b acc=%0d rdy=%b required ovf=0 acc=0 rdy=1",
                     overflow9, acc_out9, in_ready9);
        end
    endtask

    task automatic test_gapped();
        bit pattern[7] = '{1, 0, 0, 1, 0, 1, 1};
        int accepted = 0;
        begin_run();
        drive(4, 6, 1);
        for (int i = 0; i < 7; i++) begin
            in_valid = pattern[i];
            @(negedge clk);
            accepted += pattern[i];
            n_checks++;
            if (sample_cnt !== 3'(accepted) || acc_out !== 8'(11 * accepted)) begin
                n_fail++;
                $display("FAIL gapped_cycle%0d: got cnt=%0d acc=%0d required cnt=%0d acc=%0d",
                         i, sample_cnt, acc_out, accepted, 11 * accepted);
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (acc_valid !== 1'b1 || acc_out !== 8'h2C) begin
            n_fail++;
            $display("FAIL gapped_total: got vld=%b acc=%0d required vld=1 acc=44", acc_valid, acc_out);
        end
    endtask

    // Entered in HOLD with acc_out=44 from test_gapped.
    task automatic test_backpressure();
        in_valid = 1'b1;
        drive(1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            @(negedge clk);
            n_checks++;
            if (acc_valid !== 1'b1 || acc_out !== 8'd44 || sample_cnt !== 3'd4 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_cycle%0d: got vld=%b acc=%0d cnt=%0d rdy=%b required vld=1 acc=44 cnt=4 rdy=0",
                         i, acc_valid, acc_out, sample_cnt, in_ready);
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        begin_run();
        in_valid = 1'b1;
        drive(1, 2, 0);
        @(negedge clk);
        drive(2, 1, 1);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (acc_out !== 8'd7 || sample_cnt !== 3'd2) begin
            n_fail++;
            $display("FAIL midrun_partial: got acc=%0d cnt=%0d required acc=7 cnt=2", acc_out, sample_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, acc_valid, overflow, acc_out, sample_cnt} !== 13'd0) begin
            n_fail++;
            $display("FAIL midrun_async: got rdy=%b vld=%b ovf=%b acc=%0d cnt=%0d required all 0",
                     in_ready, acc_valid, overflow, acc_out, sample_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        drive(9, 9, 0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || acc_out !== 8'd0 || sample_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL midrun_nostart: got rdy=%b acc=%0d cnt=%0d required rdy=0 acc=0 cnt=0",
                     in_ready, acc_out, sample_cnt);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_start_with_valid();
        start = 1'b1;
        in_valid = 1'b1;
        drive(3, 2, 1);
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (sample_cnt !== 3'd0 || acc_out !== 8'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_valid_first: got cnt=%0d acc=%0d rdy=%b required cnt=0 acc=0 rdy=1",
                     sample_cnt, acc_out, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (sample_cnt !== 3'd1 || acc_out !== 8'd6) begin
            n_fail++;
            $display("FAIL start_valid_second: got cnt=%0d acc=%0d required cnt=1 acc=6", sample_cnt, acc_out);
        end
        do_reset();
    endtask

    // Random operands and random in_valid gaps / out_ready delays against a plain arithmetic total.
    task automatic test_random();
        for (int run = 0; run < 6; run++) begin
            int  total = 0;
            int  cnt = 0;
            int  cycles = 0;
            bit  v;
            int  a, b, c;
            @(negedge clk);
            begin_run();
            while (cnt < 4 && cycles < 200) begin
                n_checks++;
                if (acc_out !== 8'(total % 256) || sample_cnt !== 3'(cnt) || in_ready !== 1'b1 || acc_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random_run%0d_cycle%0d: got acc=%0d cnt=%0d rdy=%b vld=%b required acc=%0d cnt=%0d rdy=1 vld=0",
                             run, cycles, acc_out, sample_cnt, in_ready, acc_valid, total % 256, cnt);
                end
                v = ($urandom_range(0, 9) < 7);
                a = $urandom_range(0, 15);
                b = $urandom_range(0, 15);
                c = $urandom_range(0, 1);
                in_valid = v;
                drive(a, b, c);
                if (v) begin
                    total += a + b + c;
                    cnt++;
                end
                @(negedge clk);
                cycles++;
            end
            in_valid = 1'b0;
            n_checks++;
            if (cycles >= 200 || acc_valid !== 1'b1 || acc_out !== 8'(total % 256) ||
                overflow !== (total >= 256) || sample_cnt !== 3'd4) begin
                n_fail++;
                $display("FAIL random_run%0d_total: got vld=%b acc=%0d ovf=%b cnt=%0d required vld=1 acc=%0d ovf=%0d cnt=4",
                         run, acc_valid, acc_out, overflow, sample_cnt, total % 256, total >= 256);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            n_checks++;
            if (acc_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL random_run%0d_release: got vld=%b required vld=0", run, acc_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_gapped();
        test_backpressure();
        test_reset_midrun();
        @(negedge clk);
        test_start_with_valid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
